// File: rtl/uart_spi_pkg.sv
// rtl/uart_spi_pkg.sv - shared widths and FSM encoding for the UART/SPI word bridge
package uart_spi_pkg;
    localparam int SPI_WORD_W = 16;
    localparam int BYTE_W     = 8;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_START     = 3'd1;
    localparam logic [2:0] ST_WAIT_DONE = 3'd2;
    localparam logic [2:0] ST_SEND_HI   = 3'd3;
    localparam logic [2:0] ST_SEND_LO   = 3'd4;

    typedef enum logic [2:0] {
        IDLE      = ST_IDLE,
        START     = ST_START,
        WAIT_DONE = ST_WAIT_DONE,
        SEND_HI   = ST_SEND_HI,
        SEND_LO   = ST_SEND_LO
    } bridge_state_t;
endpackage

// File: rtl/uart_spi_word_bridge_if.sv
// rtl/uart_spi_word_bridge_if.sv - UART byte side, SPI engine side and error flags of the bridge
interface uart_spi_word_bridge_if;
    import uart_spi_pkg::*;

    logic [BYTE_W-1:0]     rx_byte;
    logic                  rx_byte_valid;
    logic [BYTE_W-1:0]     tx_byte;
    logic                  tx_byte_valid;
    logic                  tx_byte_ready;
    logic [SPI_WORD_W-1:0] spi_tx_word;
    logic                  spi_start;
    logic [SPI_WORD_W-1:0] spi_rx_word;
    logic                  spi_rx_valid;
    logic                  err_clear;
    logic                  overflow_err;
    logic                  gap_err;
    logic                  timeout_err;
    logic                  busy;

    // master is the surrounding system (UART + SPI engine), slave is the bridge
    modport master (
        output rx_byte, rx_byte_valid, tx_byte_ready, spi_rx_word, spi_rx_valid, err_clear,
        input  tx_byte, tx_byte_valid, spi_tx_word, spi_start, overflow_err, gap_err, timeout_err, busy
    );
    modport slave (
        input  rx_byte, rx_byte_valid, tx_byte_ready, spi_rx_word, spi_rx_valid, err_clear,
        output tx_byte, tx_byte_valid, spi_tx_word, spi_start, overflow_err, gap_err, timeout_err, busy
    );
endinterface

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO; a push while full is accepted only if a pop frees the slot
module sync_fifo #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [DATA_W-1:0]        push_data,
    input  logic                     pop,
    output logic [DATA_W-1:0]        pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign full     = (count == (AW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
        end
    end
endmodule

// File: rtl/uart_spi_word_bridge.sv
// rtl/uart_spi_word_bridge.sv - packs UART byte pairs into SPI words, runs one SPI frame per word,
// and returns each received SPI word to the UART as two bytes (high byte first)
module uart_spi_word_bridge
    import uart_spi_pkg::*;
#(
    parameter int DATA_WIDTH      = 16,
    parameter int FIFO_DEPTH      = 4,
    parameter int TIMEOUT_CYCLES  = 4096,
    parameter int BYTE_GAP_CYCLES = 65535
) (
    input  logic                    clk,
    input  logic                    reset,
    uart_spi_word_bridge_if.slave   bus
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int GW = $clog2(BYTE_GAP_CYCLES + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [GW-1:0] GAP_LAST   = GW'(BYTE_GAP_CYCLES - 1);

    bridge_state_t           state;
    logic [TW-1:0]           timer;
    logic [DATA_WIDTH-1:0]   word_q;
    logic [DATA_WIDTH-1:0]   captured;
    logic                    pending;
    logic [BYTE_W-1:0]       hi_byte;
    logic [GW-1:0]           gap_cnt;
    logic                    overflow_q;
    logic                    gap_q;
    logic                    timeout_q;

    logic                    push;
    logic                    pop;
    logic [DATA_WIDTH-1:0]   fifo_head;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;
    logic                    unused_fifo_count;
    logic                    gap_hit;
    logic                    overflow_set;
    logic                    timeout_set;

    assign push         = bus.rx_byte_valid && pending;
    assign pop          = (state == IDLE) && !fifo_empty;
    assign gap_hit      = pending && !bus.rx_byte_valid && (gap_cnt == GAP_LAST);
    assign overflow_set = push && fifo_full && !pop;
    assign timeout_set  = (state == WAIT_DONE) && !bus.spi_rx_valid && (timer == TIMER_LAST);
    assign unused_fifo_count = ^fifo_count;

    sync_fifo #(
        .DATA_W (DATA_WIDTH),
        .DEPTH  (FIFO_DEPTH)
    ) u_tx_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data ({hi_byte, bus.rx_byte}),
        .pop       (pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Byte assembler: the first byte of a pair waits in hi_byte until its partner or the gap limit
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending <= 1'b0;
            hi_byte <= '0;
            gap_cnt <= '0;
        end else if (bus.rx_byte_valid) begin
            if (pending) begin
                pending <= 1'b0;
            end else begin
                pending <= 1'b1;
                hi_byte <= bus.rx_byte;
                gap_cnt <= '0;
            end
        end else if (pending) begin
            if (gap_hit) begin
                pending <= 1'b0;
            end else begin
                gap_cnt <= gap_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            timer    <= '0;
            word_q   <= '0;
            captured <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        word_q <= fifo_head;
                        state  <= START;
                    end
                end
                START: begin
                    timer <= '0;
                    state <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    // a completion arriving on the last allowed cycle still counts
                    if (bus.spi_rx_valid) begin
                        captured <= bus.spi_rx_word;
                        state    <= SEND_HI;
                    end else if (timer == TIMER_LAST) begin
                        state <= IDLE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                SEND_HI: begin
                    if (bus.tx_byte_ready) begin
                        state <= SEND_LO;
                    end
                end
                SEND_LO: begin
                    if (bus.tx_byte_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Sticky flags: a new error in the same cycle as err_clear keeps the flag set
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow_q <= 1'b0;
            gap_q      <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            if (overflow_set)       overflow_q <= 1'b1;
            else if (bus.err_clear) overflow_q <= 1'b0;
            if (gap_hit)            gap_q      <= 1'b1;
            else if (bus.err_clear) gap_q      <= 1'b0;
            if (timeout_set)        timeout_q  <= 1'b1;
            else if (bus.err_clear) timeout_q  <= 1'b0;
        end
    end

    assign bus.spi_tx_word   = word_q;
    assign bus.spi_start     = (state == START);
    assign bus.tx_byte_valid = (state == SEND_HI) || (state == SEND_LO);
    assign bus.tx_byte       = (state == SEND_HI) ? captured[15:8] : captured[7:0];
    assign bus.busy          = (state != IDLE);
    assign bus.overflow_err  = overflow_q;
    assign bus.gap_err       = gap_q;
    assign bus.timeout_err   = timeout_q;
endmodule

// File: tb/tb_uart_spi_word_bridge.sv
// tb/tb_uart_spi_word_bridge.sv - self-checking bench: vector table, random traffic, error corner cases
module tb_uart_spi_word_bridge;
    localparam int TIMEOUT = 4096;
    localparam int GAP     = 300;
    localparam int DEPTH   = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    uart_spi_word_bridge_if bus();

    uart_spi_word_bridge #(
        .DATA_WIDTH      (16),
        .FIFO_DEPTH      (DEPTH),
        .TIMEOUT_CYCLES  (TIMEOUT),
        .BYTE_GAP_CYCLES (GAP)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // SPI engine model: records each started word and answers after a latency unless stalled
    logic        stall = 1'b0;
    logic        spurious_en = 1'b0;
    logic        rand_lat = 1'b0;
    logic        use_fixed = 1'b0;
    logic [15:0] fixed_resp = 16'h0;
    int          latency = 2;
    int          resp_cnt = -1;
    logic [15:0] resp_word = 16'h0;
    logic [15:0] started_q[$];
    int          start_cyc_q[$];

    function automatic logic [15:0] resp_of(input logic [15:0] w);
        return use_fixed ? fixed_resp : ({w[7:0], w[15:8]} ^ 16'h0F0F);
    endfunction

    initial begin
        bus.spi_rx_valid = 1'b0;
        bus.spi_rx_word  = 16'h0;
        forever begin
            @(negedge clk);
            bus.spi_rx_valid = 1'b0;
            if (reset) begin
                resp_cnt = -1;
            end else begin
                if (resp_cnt == 0) begin
                    bus.spi_rx_valid = 1'b1;
                    bus.spi_rx_word  = resp_word;
                    resp_cnt = -1;
                end else if (resp_cnt > 0) begin
                    resp_cnt--;
                end else if (resp_cnt == -1 && spurious_en && !bus.spi_start && $urandom_range(0, 7) == 0) begin
                    bus.spi_rx_valid = 1'b1;
                    bus.spi_rx_word  = 16'($urandom);
                end
                if (bus.spi_start) begin
                    started_q.push_back(bus.spi_tx_word);
                    start_cyc_q.push_back(cyc);
                    resp_word = resp_of(bus.spi_tx_word);
                    resp_cnt = stall ? -2 : (rand_lat ? int'($urandom_range(0, 5)) : latency);
                end
            end
        end
    end

    // UART TX sink: collects handshaken bytes and checks that an offered byte is never retracted
    int         ready_mode = 0;
    logic [7:0] got_q[$];

    initial begin
        logic       pv;
        logic [7:0] pb;
        pv = 1'b0;
        pb = 8'h0;
        bus.tx_byte_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                pv = 1'b0;
            end else begin
                if (pv) begin
                    check("tx_valid_held", bus.tx_byte_valid, 1);
                    check("tx_byte_stable", bus.tx_byte, pb);
                end
                bus.tx_byte_ready = (ready_mode == 0) ? 1'b1 :
                                    (ready_mode == 1) ? ($urandom_range(0, 2) != 0) : 1'b0;
                if (bus.tx_byte_valid && bus.tx_byte_ready) begin
                    got_q.push_back(bus.tx_byte);
                    pv = 1'b0;
                end else begin
                    pv = bus.tx_byte_valid;
                    pb = bus.tx_byte;
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, output int n);
        @(negedge clk);
        bus.rx_byte       = b;
        bus.rx_byte_valid = 1'b1;
        n = cyc;
        @(negedge clk);
        bus.rx_byte_valid = 1'b0;
    endtask

    task automatic send_word(input logic [15:0] w);
        int n;
        send_byte(w[15:8], n);
        send_byte(w[7:0], n);
    endtask

    task automatic pulse_clear();
        @(negedge clk);
        bus.err_clear = 1'b1;
        @(negedge clk);
        bus.err_clear = 1'b0;
    endtask

    task automatic clear_q();
        started_q.delete();
        start_cyc_q.delete();
        got_q.delete();
    endtask

    task automatic wait_bytes(input string name, input int n, input int budget);
        int k;
        k = 0;
        while (got_q.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        check({name, " bytes arrived"}, got_q.size() >= n, 1);
        repeat (4) @(negedge clk);
    endtask

    task automatic cmp_all(input string name, input logic [15:0] ew[$], input logic [7:0] eb[$]);
        check({name, " word count"}, started_q.size(), ew.size());
        foreach (ew[i]) if (i < started_q.size()) check($sformatf("%s word%0d", name, i), started_q[i], ew[i]);
        check({name, " byte count"}, got_q.size(), eb.size());
        foreach (eb[i]) if (i < got_q.size()) check($sformatf("%s byte%0d", name, i), got_q[i], eb[i]);
    endtask

    typedef struct {
        logic [7:0]  hi;
        logic [7:0]  lo;
        logic [15:0] resp;
        logic [15:0] exp_word;
        logic [7:0]  exp_hi;
        logic [7:0]  exp_lo;
    } vec_t;

    vec_t        vecs[4];
    logic [15:0] ew[$];
    logic [7:0]  eb[$];
    logic [15:0] w;
    logic [15:0] r;
    int          n;
    int          m;
    int          s;
    int          k;

    initial begin
        vecs[0] = '{8'hA5, 8'h3C, 16'h1234, 16'hA53C, 8'h12, 8'h34};
        vecs[1] = '{8'hFF, 8'h00, 16'h0000, 16'hFF00, 8'h00, 8'h00};
        vecs[2] = '{8'h00, 8'hFF, 16'hFFFF, 16'h00FF, 8'hFF, 8'hFF};
        vecs[3] = '{8'h5A, 8'hC3, 16'h8001, 16'h5AC3, 8'h80, 8'h01};

        bus.rx_byte = 8'h0;
        bus.rx_byte_valid = 1'b0;
        bus.err_clear = 1'b0;

        // reset state
        repeat (3) @(negedge clk);
        check("rst tx_byte_valid", bus.tx_byte_valid, 0);
        check("rst spi_start", bus.spi_start, 0);
        check("rst busy", bus.busy, 0);
        check("rst overflow_err", bus.overflow_err, 0);
        check("rst gap_err", bus.gap_err, 0);
        check("rst timeout_err", bus.timeout_err, 0);
        check("rst spi_tx_word", bus.spi_tx_word, 0);
        check("rst tx_byte", bus.tx_byte, 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check("post-rst busy", bus.busy, 0);

        // vector table: latency, word packing, byte split
        use_fixed = 1'b1;
        for (int i = 0; i < 4; i++) begin
            clear_q();
            fixed_resp = vecs[i].resp;
            send_byte(vecs[i].hi, n);
            send_byte(vecs[i].lo, n);
            wait_bytes($sformatf("vec%0d", i), 2, 200);
            check($sformatf("vec%0d start latency", i), start_cyc_q.size() > 0 ? start_cyc_q[0] - n : -1, 2);
            check($sformatf("vec%0d spi_tx_word", i), started_q.size() > 0 ? started_q[0] : 16'hxxxx, vecs[i].exp_word);
            check($sformatf("vec%0d tx hi", i), got_q.size() > 0 ? got_q[0] : 8'hxx, vecs[i].exp_hi);
            check($sformatf("vec%0d tx lo", i), got_q.size() > 1 ? got_q[1] : 8'hxx, vecs[i].exp_lo);
            check($sformatf("vec%0d busy after", i), bus.busy, 0);
        end
        use_fixed = 1'b0;

        // random traffic against a word-level model, outstanding words kept below FIFO capacity
        clear_q();
        ew.delete();
        eb.delete();
        spurious_en = 1'b1;
        rand_lat = 1'b1;
        ready_mode = 1;
        for (int i = 0; i < 30; i++) begin
            w = 16'($urandom);
            k = 0;
            while (ew.size() - started_q.size() > 2 && k < 2000) begin
                @(negedge clk);
                k++;
            end
            send_byte(w[15:8], n);
            repeat ($urandom_range(0, 10)) @(negedge clk);
            send_byte(w[7:0], n);
            ew.push_back(w);
            r = resp_of(w);
            eb.push_back(r[15:8]);
            eb.push_back(r[7:0]);
            repeat ($urandom_range(0, 6)) @(negedge clk);
        end
        wait_bytes("random", 60, 5000);
        cmp_all("random", ew, eb);
        check("random no errors", {bus.overflow_err, bus.gap_err, bus.timeout_err}, 0);
        spurious_en = 1'b0;
        rand_lat = 1'b0;
        ready_mode = 0;
        latency = 2;

        // overflow: engine stalled, 1 in flight + DEPTH queued, 6th dropped
        clear_q();
        ew.delete();
        eb.delete();
        stall = 1'b1;
        for (int i = 0; i < 6; i++) begin
            w = 16'h1100 + 16'(i * 16'h0101);
            send_word(w);
            if (i < 5) ew.push_back(w);
        end
        repeat (2) @(negedge clk);
        check("ovf overflow_err", bus.overflow_err, 1);
        check("ovf in flight", started_q.size(), 1);
        pulse_clear();
        @(negedge clk);
        check("ovf cleared", bus.overflow_err, 0);
        // simultaneous pop and push at full must not flag overflow
        send_byte(8'h7E, n);
        stall = 1'b0;
        resp_cnt = 0;
        k = 0;
        @(negedge clk);
        while (bus.busy && k < 200) begin
            @(negedge clk);
            k++;
        end
        bus.rx_byte = 8'h81;
        bus.rx_byte_valid = 1'b1;
        @(negedge clk);
        bus.rx_byte_valid = 1'b0;
        ew.push_back(16'h7E81);
        foreach (ew[i]) begin
            r = resp_of(ew[i]);
            eb.push_back(r[15:8]);
            eb.push_back(r[7:0]);
        end
        wait_bytes("ovf", 12, 500);
        cmp_all("ovf", ew, eb);
        check("ovf full pop+push no error", bus.overflow_err, 0);

        // byte gap timeout, err_clear on the setting cycle loses
        clear_q();
        send_byte(8'h77, m);
        k = 0;
        while (cyc < m + GAP && k < GAP + 10) begin
            @(negedge clk);
            k++;
        end
        check("gap not yet", bus.gap_err, 0);
        bus.err_clear = 1'b1;
        @(negedge clk);
        bus.err_clear = 1'b0;
        check("gap set wins", bus.gap_err, 1);
        send_word(16'h0102);
        wait_bytes("gap", 2, 200);
        r = resp_of(16'h0102);
        ew.delete();
        eb.delete();
        ew.push_back(16'h0102);
        eb.push_back(r[15:8]);
        eb.push_back(r[7:0]);
        cmp_all("gap", ew, eb);
        pulse_clear();
        @(negedge clk);
        check("gap cleared", bus.gap_err, 0);

        // SPI timeout: no response at all
        clear_q();
        stall = 1'b1;
        send_word(16'h5566);
        k = 0;
        while (start_cyc_q.size() == 0 && k < 50) begin
            @(negedge clk);
            k++;
        end
        s = (start_cyc_q.size() > 0) ? start_cyc_q[0] : cyc;
        k = 0;
        while (cyc < s + TIMEOUT && k < TIMEOUT + 10) begin
            @(negedge clk);
            k++;
        end
        check("to last cycle err", bus.timeout_err, 0);
        check("to last cycle busy", bus.busy, 1);
        @(negedge clk);
        check("to timeout_err", bus.timeout_err, 1);
        check("to busy", bus.busy, 0);
        check("to no tx bytes", got_q.size(), 0);
        stall = 1'b0;
        resp_cnt = -1;
        send_word(16'h6677);
        wait_bytes("to next", 2, 200);
        r = resp_of(16'h6677);
        ew.delete();
        eb.delete();
        ew.push_back(16'h5566);
        ew.push_back(16'h6677);
        eb.push_back(r[15:8]);
        eb.push_back(r[7:0]);
        cmp_all("to", ew, eb);
        pulse_clear();

        // response on the final timeout cycle is accepted
        clear_q();
        latency = TIMEOUT - 1;
        send_word(16'h0A0B);
        wait_bytes("to edge", 2, TIMEOUT + 100);
        check("to edge no err", bus.timeout_err, 0);
        r = resp_of(16'h0A0B);
        check("to edge hi", got_q.size() > 0 ? got_q[0] : 8'hxx, r[15:8]);
        check("to edge lo", got_q.size() > 1 ? got_q[1] : 8'hxx, r[7:0]);
        latency = 2;

        // UART backpressure for 50 cycles in SEND_HI
        clear_q();
        ready_mode = 2;
        send_word(16'hC0DE);
        k = 0;
        while (!bus.tx_byte_valid && k < 50) begin
            @(negedge clk);
            k++;
        end
        r = resp_of(16'hC0DE);
        check("bp hi offered", bus.tx_byte, r[15:8]);
        repeat (50) @(negedge clk);
        check("bp nothing sent", got_q.size(), 0);
        check("bp valid held", bus.tx_byte_valid, 1);
        check("bp hi held", bus.tx_byte, r[15:8]);
        ready_mode = 0;
        wait_bytes("bp", 2, 100);
        repeat (10) @(negedge clk);
        check("bp exactly two", got_q.size(), 2);
        check("bp lo", got_q.size() > 1 ? got_q[1] : 8'hxx, r[7:0]);

        // asynchronous reset mid-frame drops in-flight, queued and half-assembled data
        clear_q();
        stall = 1'b1;
        send_word(16'h1111);
        send_word(16'h2222);
        send_byte(8'h33, n);
        repeat (3) @(negedge clk);
        check("mid busy", bus.busy, 1);
        #2;
        reset = 1'b1;
        #1;
        check("arst busy", bus.busy, 0);
        check("arst tx_byte_valid", bus.tx_byte_valid, 0);
        check("arst spi_start", bus.spi_start, 0);
        check("arst spi_tx_word", bus.spi_tx_word, 0);
        check("arst tx_byte", bus.tx_byte, 0);
        check("arst flags", {bus.overflow_err, bus.gap_err, bus.timeout_err}, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        stall = 1'b0;
        clear_q();
        send_word(16'hBEEF);
        wait_bytes("post-rst", 2, 200);
        repeat (10) @(negedge clk);
        r = resp_of(16'hBEEF);
        ew.delete();
        eb.delete();
        ew.push_back(16'hBEEF);
        eb.push_back(r[15:8]);
        eb.push_back(r[7:0]);
        cmp_all("post-rst", ew, eb);
        check("post-rst idle", bus.busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
